cp0_regfile: RTL and testbench



---
 rtl/cp0_regfile_pkg.sv | 51 +++++
 rtl/cp0_regfile_if.sv | 40 ++++
 rtl/cp0_regfile_timer.sv | 74 +++++++
 rtl/cp0_regfile.sv | 134 +++++++++++++
 tb/tb_cp0_regfile.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_regfile_pkg.sv
// cp0_defs: shared definitions for the coprocessor-0 register file.
// Holds the CP0 register numbers, the exception type codes produced by the
// memory-stage exception unit, Status/Cause bit positions, the Status reset
// value, the MTC0 write masks and a helper that maps a type to ExcCode.
package cp0_defs;

    // CP0 register numbers (rd field of MFC0/MTC0)
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;
    localparam logic [4:0] REG_CONFIG   = 5'd16;

    // Resolved exception types from the exception unit
    localparam logic [31:0] EXC_NONE = 32'h0000_0000;
    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_BP   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI   = 32'h0000_000A;
    localparam logic [31:0] EXC_OV   = 32'h0000_000C;
    localparam logic [31:0] EXC_ERET = 32'h0000_000E;

    // Status bit positions
    localparam int STATUS_IE_BIT  = 0;
    localparam int STATUS_EXL_BIT = 1;

    // Cause bit positions
    localparam int CAUSE_EXC_LSB   = 2;
    localparam int CAUSE_EXC_MSB   = 6;
    localparam int CAUSE_IP_HW_LSB = 10;
    localparam int CAUSE_IP_HW_MSB = 15;
    localparam int CAUSE_TI_BIT    = 30;
    localparam int CAUSE_BD_BIT    = 31;

    // Reset value and software-writable bits
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;  // BEV=1
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;  // IM, EXL, IE
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;  // software IP[9:8]

    // Interrupts report ExcCode 0; every other type reports its own low bits,
    // which also covers unknown nonzero types.
    function automatic logic [4:0] exc_code(input logic [31:0] etype);
        return (etype == EXC_INT) ? 5'd0 : etype[4:0];
    endfunction

endpackage

// File: rtl/cp0_regfile_if.sv
// cp0_regfile_if: bundles the MTC0/MFC0 port, the exception-commit inputs
// and the registered CP0 mirrors between the pipeline and the CP0 block.
//   master : pipeline side (drives writes, reads, exception info)
//   slave  : cp0_regfile side (returns read data and register mirrors)
interface cp0_regfile_if;
    // MTC0 / MFC0
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    // Interrupt lines and exception commit
    logic [5:0]  ext_int_i;
    logic [31:0] except_type_i;
    logic [31:0] pc_i;
    logic        in_delayslot_i;
    logic [31:0] badvaddr_i;
    // Registered contents
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic [31:0] count_o;
    logic [31:0] compare_o;
    logic [31:0] badvaddr_o;
    logic        timer_int_o;

    modport master (
        output we_i, waddr_i, wdata_i, raddr_i,
        output ext_int_i, except_type_i, pc_i, in_delayslot_i, badvaddr_i,
        input  rdata_o, status_o, cause_o, epc_o, count_o, compare_o,
        input  badvaddr_o, timer_int_o
    );

    modport slave (
        input  we_i, waddr_i, wdata_i, raddr_i,
        input  ext_int_i, except_type_i, pc_i, in_delayslot_i, badvaddr_i,
        output rdata_o, status_o, cause_o, epc_o, count_o, compare_o,
        output badvaddr_o, timer_int_o
    );
endinterface

// File: rtl/cp0_regfile_timer.sv
// cp0_timer: Count/Compare timer for CP0.
// Count advances on every other clock (internal tick), wrapping at 2^32.
// timer_int_o latches when the incremented Count hits a nonzero Compare and
// stays set until Compare is written.
// Ports:
//   clk, rst        : clock, async active-high reset
//   count_we_i      : load Count from wdata_i (suppresses this cycle's step)
//   compare_we_i    : load Compare from wdata_i and clear timer_int_o
//   wdata_i         : MTC0 data
//   count_o         : Count register
//   compare_o       : Compare register
//   timer_int_o     : sticky timer interrupt
module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    logic        tick_q, tick_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        timer_int_q, timer_int_d;
    logic [31:0] count_inc;
    logic        match;

    always_comb begin
        tick_d      = ~tick_q;
        count_d     = count_q;
        compare_d   = compare_q;
        timer_int_d = timer_int_q;
        count_inc   = count_q + 32'd1;
        // Only a real increment can produce a match; a Count load skips it.
        match = tick_q && !count_we_i && (compare_q != 32'd0) &&
                (count_inc == compare_q);

        if (count_we_i) begin
            count_d = wdata_i;
        end else if (tick_q) begin
            count_d = count_inc;
        end

        // A Compare write beats a coincident match.
        if (compare_we_i) begin
            compare_d   = wdata_i;
            timer_int_d = 1'b0;
        end else if (match) begin
            timer_int_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q      <= 1'b0;
            count_q     <= 32'd0;
            compare_q   <= 32'd0;
            timer_int_q <= 1'b0;
        end else begin
            tick_q      <= tick_d;
            count_q     <= count_d;
            compare_q   <= compare_d;
            timer_int_q <= timer_int_d;
        end
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = timer_int_q;

endmodule

// File: rtl/cp0_regfile.sv
// cp0_regfile: coprocessor-0 register file for the five-stage MIPS core.
// Commits resolved exceptions from the memory-stage exception unit into
// Status/Cause/EPC/BadVAddr, serves MFC0/MTC0, and hosts the Count/Compare
// timer whose interrupt is folded into Cause.IP[15] and Cause.TI.
// Ports:
//   clk, rst : clock, async active-high reset
//   bus      : cp0_regfile_if.slave (MTC0/MFC0, exception inputs, mirrors)
// Parameters:
//   PRID, CONFIG : constant read values of registers 15 and 16
module cp0_regfile
    import cp0_defs::*;
#(
    parameter logic [31:0] PRID   = 32'h0000_4220,
    parameter logic [31:0] CONFIG = 32'h8000_0000
) (
    input  logic         clk,
    input  logic         rst,
    cp0_regfile_if.slave bus
);

    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;

    logic        exc_valid;
    logic        eret;
    logic        mtc0;
    logic        addr_exc;
    logic        count_we;
    logic        compare_we;
    logic [31:0] count;
    logic [31:0] compare;
    logic        timer_int;
    logic [31:0] rdata;

    // Any nonzero type other than ERET is an exception. A faulting or ERET
    // instruction does not retire, so its MTC0 is dropped.
    assign exc_valid  = (bus.except_type_i != EXC_NONE) &&
                        (bus.except_type_i != EXC_ERET);
    assign eret       = (bus.except_type_i == EXC_ERET);
    assign mtc0       = bus.we_i && (bus.except_type_i == EXC_NONE);
    assign addr_exc   = (bus.except_type_i == EXC_ADEL) ||
                        (bus.except_type_i == EXC_ADES);
    assign count_we   = mtc0 && (bus.waddr_i == REG_COUNT);
    assign compare_we = mtc0 && (bus.waddr_i == REG_COMPARE);

    cp0_timer u_timer (
        .clk          (clk),
        .rst          (rst),
        .count_we_i   (count_we),
        .compare_we_i (compare_we),
        .wdata_i      (bus.wdata_i),
        .count_o      (count),
        .compare_o    (compare),
        .timer_int_o  (timer_int)
    );

    always_comb begin
        status_d   = status_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;

        // Hardware interrupt pending bits track the lines every cycle; the
        // timer shares IP7 with ext_int_i[5].
        cause_d[CAUSE_IP_HW_MSB:CAUSE_IP_HW_LSB] =
            {bus.ext_int_i[5] | timer_int, bus.ext_int_i[4:0]};
        cause_d[CAUSE_TI_BIT] = timer_int;

        if (exc_valid) begin
            // Nested exceptions keep the original return point.
            if (!status_q[STATUS_EXL_BIT]) begin
                epc_d = bus.in_delayslot_i ? (bus.pc_i - 32'd4) : bus.pc_i;
                cause_d[CAUSE_BD_BIT] = bus.in_delayslot_i;
            end
            status_d[STATUS_EXL_BIT] = 1'b1;
            cause_d[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = exc_code(bus.except_type_i);
            if (addr_exc) begin
                badvaddr_d = bus.badvaddr_i;
            end
        end else if (eret) begin
            status_d[STATUS_EXL_BIT] = 1'b0;
        end else if (mtc0) begin
            case (bus.waddr_i)
                REG_STATUS: status_d = (status_q & ~STATUS_WMASK) |
                                       (bus.wdata_i & STATUS_WMASK);
                REG_CAUSE: cause_d[9:8] = bus.wdata_i[9:8];
                REG_EPC:    epc_d = bus.wdata_i;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q   <= STATUS_RESET;
            cause_q    <= 32'd0;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    // MFC0 read: current register contents, no bypass of a same-cycle MTC0.
    always_comb begin
        rdata = 32'd0;
        case (bus.raddr_i)
            REG_BADVADDR: rdata = badvaddr_q;
            REG_COUNT:    rdata = count;
            REG_COMPARE:  rdata = compare;
            REG_STATUS:   rdata = status_q;
            REG_CAUSE:    rdata = cause_q;
            REG_EPC:      rdata = epc_q;
            REG_PRID:     rdata = PRID;
            REG_CONFIG:   rdata = CONFIG;
            default:      rdata = 32'd0;
        endcase
    end

    assign bus.rdata_o     = rdata;
    assign bus.status_o    = status_q;
    assign bus.cause_o     = cause_q;
    assign bus.epc_o       = epc_q;
    assign bus.count_o     = count;
    assign bus.compare_o   = compare;
    assign bus.badvaddr_o  = badvaddr_q;
    assign bus.timer_int_o = timer_int;

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: hand-written sequences for reset, the
// Count/Compare timer and its corner cases, plus a vector table for
// MTC0/MFC0 and exception commit checked through a scoreboard queue.
module tb_cp0_regfile;

    logic clk;
    logic rst;
    int   n_err;
    int   n_chk;

    cp0_regfile_if bus_if ();

    cp0_regfile #(
        .PRID   (32'h0000_4220),
        .CONFIG (32'h8000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr;
        logic [5:0]  ext;
        logic [31:0] etype;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] bva;
        logic [31:0] e_status;
        logic [31:0] e_cause;
        logic [31:0] e_epc;
        logic [31:0] e_badv;
        logic [31:0] e_rdata;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] badv;
        logic [31:0] rdata;
        logic        timer;
    } exp_t;

    localparam int NV = 20;
    vec_t vecs [NV];
    exp_t sb_q [$];

    function automatic vec_t mk(
        input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
        input logic [4:0] raddr, input logic [5:0] ext,
        input logic [31:0] etype, input logic [31:0] pc, input logic ds,
        input logic [31:0] bva, input logic [31:0] e_status,
        input logic [31:0] e_cause, input logic [31:0] e_epc,
        input logic [31:0] e_badv, input logic [31:0] e_rdata);
        vec_t v;
        v.we = we; v.waddr = waddr; v.wdata = wdata; v.raddr = raddr;
        v.ext = ext; v.etype = etype; v.pc = pc; v.ds = ds; v.bva = bva;
        v.e_status = e_status; v.e_cause = e_cause; v.e_epc = e_epc;
        v.e_badv = e_badv; v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] waddr,
                         input logic [31:0] wdata, input logic [4:0] raddr,
                         input logic [5:0] ext, input logic [31:0] etype,
                         input logic [31:0] pc, input logic ds,
                         input logic [31:0] bva);
        bus_if.we_i           = we;
        bus_if.waddr_i        = waddr;
        bus_if.wdata_i        = wdata;
        bus_if.raddr_i        = raddr;
        bus_if.ext_int_i      = ext;
        bus_if.except_type_i  = etype;
        bus_if.pc_i           = pc;
        bus_if.in_delayslot_i = ds;
        bus_if.badvaddr_i     = bva;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 5'd0, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        drive(1'b1, addr, data, 5'd0, 6'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    endtask

    // Advance n rising edges and settle just after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_status"},   bus_if.status_o,    32'h0040_0000);
        chk({tag, "_cause"},    bus_if.cause_o,     32'd0);
        chk({tag, "_epc"},      bus_if.epc_o,       32'd0);
        chk({tag, "_count"},    bus_if.count_o,     32'd0);
        chk({tag, "_compare"},  bus_if.compare_o,   32'd0);
        chk({tag, "_badvaddr"}, bus_if.badvaddr_o,  32'd0);
        chk({tag, "_timer"},    {31'd0, bus_if.timer_int_o}, 32'd0);
    endtask

    initial begin
        logic [31:0] prev;
        bit          seen;
        exp_t        e;

        n_err = 0;
        n_chk = 0;
        rst   = 1'b1;
        idle();

        // -------- reset and free-running count --------
        step(2);
        rst = 1'b0;
        chk_reset_state("reset");
        bus_if.raddr_i = 5'd15;
        #1;
        chk("prid_read", bus_if.rdata_o, 32'h0000_4220);
        bus_if.raddr_i = 5'd0;
        step(10);
        $display("idle 10 cycles: count=%0d", bus_if.count_o);
        chk("idle10_count",  bus_if.count_o,  32'd5);
        chk("idle10_status", bus_if.status_o, 32'h0040_0000);
        chk("idle10_cause",  bus_if.cause_o,  32'd0);
        chk("idle10_epc",    bus_if.epc_o,    32'd0);

        // -------- timer interrupt from a fresh reset --------
        rst = 1'b1;
        #1;
        chk("async_rst_count", bus_if.count_o, 32'd0);
        step(1);
        rst = 1'b0;
        mtc0(5'd11, 32'd3);
        step(1);
        idle();
        chk("cmp3_compare", bus_if.compare_o, 32'd3);
        step(4);
        chk("cmp3_pre_timer", {31'd0, bus_if.timer_int_o}, 32'd0);
        chk("cmp3_pre_count", bus_if.count_o, 32'd2);
        step(1);
        $display("timer match: count=%0d timer_int=%0b", bus_if.count_o, bus_if.timer_int_o);
        chk("cmp3_timer", {31'd0, bus_if.timer_int_o}, 32'd1);
        chk("cmp3_count", bus_if.count_o, 32'd3);
        step(1);
        chk("cmp3_cause_ip7_ti", bus_if.cause_o, 32'h4000_8000);
        mtc0(5'd11, 32'd100);
        step(1);
        idle();
        chk("cmp100_timer_clr", {31'd0, bus_if.timer_int_o}, 32'd0);
        chk("cmp100_count", bus_if.count_o, 32'd4);
        step(1);
        chk("cmp100_cause_clr", bus_if.cause_o, 32'd0);

        // -------- table: MTC0/MFC0 and exception commit --------
        vecs[0]  = mk(1, 12, 32'hFFFF_FFFF, 12, 6'd0, 32'h0, 32'h0, 0, 32'h0,
                      32'h0040_FF03, 32'h0, 32'h0, 32'h0, 32'h0040_FF03);
        vecs[1]  = mk(1, 12, 32'h0000_0101, 12, 6'd0, 32'h0, 32'h0, 0, 32'h0,
                      32'h0040_0101, 32'h0, 32'h0, 32'h0, 32'h0040_0101);
        vecs[2]  = mk(1, 13, 32'hFFFF_FFFF, 13, 6'd0, 32'h0, 32'h0, 0, 32'h0,
                      32'h0040_0101, 32'h300, 32'h0, 32'h0, 32'h300);
        vecs[3]  = mk(1, 8, 32'h0000_1234, 8, 6'd0, 32'h0, 32'h0, 0, 32'h0,
                      32'h0040_0101, 32'h300, 32'h0, 32'h0, 32'h0);
        vecs[4]  = mk(1, 14, 32'h8000_0010, 14, 6'd0, 32'h0, 32'h0, 0, 32'h0,
                      32'h0040_0101, 32'h300, 32'h8000_0010, 32'h0, 32'h8000_0010);
        vecs[5]  = mk(1, 20, 32'h0000_DEAD, 20, 6'd0, 32'h0, 32'h0, 0, 32'h0,
                      32'h0040_0101, 32'h300, 32'h8000_0010, 32'h0, 32'h0);
        vecs[6]  = mk(0, 0, 32'h0, 13, 6'b100001, 32'h0, 32'h0, 0, 32'h0,
                      32'h0040_0101, 32'h8700, 32'h8000_0010, 32'h0, 32'h8700);
        vecs[7]  = mk(1, 13, 32'h0, 13, 6'd0, 32'h0, 32'h0, 0, 32'h0,
                      32'h0040_0101, 32'h0, 32'h8000_0010, 32'h0, 32'h0);
        vecs[8]  = mk(0, 0, 32'h0, 8, 6'd0, 32'h4, 32'hBFC0_0100, 1, 32'h3,
                      32'h0040_0103, 32'h8000_0010, 32'hBFC0_00FC, 32'h3, 32'h3);
        vecs[9]  = mk(0, 0, 32'h0, 14, 6'd0, 32'h8, 32'h0000_0100, 0, 32'h0,
                      32'h0040_0103, 32'h8000_0020, 32'hBFC0_00FC, 32'h3, 32'hBFC0_00FC);
        vecs[10] = mk(0, 0, 32'h0, 12, 6'd0, 32'hE, 32'h0, 0, 32'h0,
                      32'h0040_0101, 32'h8000_0020, 32'hBFC0_00FC, 32'h3, 32'h0040_0101);
        vecs[11] = mk(1, 12, 32'h0, 12, 6'd0, 32'h0, 32'h0, 0, 32'h0,
                      32'h0040_0000, 32'h8000_0020, 32'hBFC0_00FC, 32'h3, 32'h0040_0000);
        vecs[12] = mk(1, 12, 32'hFFFF_FFFF, 13, 6'd0, 32'hC, 32'h0000_0200, 0, 32'h0,
                      32'h0040_0002, 32'h30, 32'h200, 32'h3, 32'h30);
        vecs[13] = mk(0, 0, 32'h0, 14, 6'd0, 32'h1, 32'h0000_0204, 1, 32'h77,
                      32'h0040_0002, 32'h0, 32'h200, 32'h3, 32'h200);
        vecs[14] = mk(0, 0, 32'h0, 12, 6'd0, 32'hE, 32'h0, 0, 32'h0,
                      32'h0040_0000, 32'h0, 32'h200, 32'h3, 32'h0040_0000);
        vecs[15] = mk(0, 0, 32'h0, 8, 6'd0, 32'h5, 32'h0000_0300, 0, 32'hABCD,
                      32'h0040_0002, 32'h14, 32'h300, 32'hABCD, 32'hABCD);
        vecs[16] = mk(0, 0, 32'h0, 13, 6'd0, 32'h1F, 32'h0000_0400, 1, 32'h9999,
                      32'h0040_0002, 32'h7C, 32'h300, 32'hABCD, 32'h7C);
        vecs[17] = mk(1, 14, 32'h0000_5555, 14, 6'd0, 32'hE, 32'h0, 0, 32'h0,
                      32'h0040_0000, 32'h7C, 32'h300, 32'hABCD, 32'h300);
        vecs[18] = mk(0, 0, 32'h0, 15, 6'd0, 32'h0, 32'h0, 0, 32'h0,
                      32'h0040_0000, 32'h7C, 32'h300, 32'hABCD, 32'h0000_4220);
        vecs[19] = mk(0, 0, 32'h0, 16, 6'd0, 32'h0, 32'h0, 0, 32'h0,
                      32'h0040_0000, 32'h7C, 32'h300, 32'hABCD, 32'h8000_0000);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].raddr,
                  vecs[i].ext, vecs[i].etype, vecs[i].pc, vecs[i].ds, vecs[i].bva);
            e.idx = i;
            e.status = vecs[i].e_status;
            e.cause  = vecs[i].e_cause;
            e.epc    = vecs[i].e_epc;
            e.badv   = vecs[i].e_badv;
            e.rdata  = vecs[i].e_rdata;
            e.timer  = 1'b0;
            sb_q.push_back(e);
            step(1);
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                $display("vec %0d: status=%08h cause=%08h epc=%08h badv=%08h rdata=%08h",
                         e.idx, bus_if.status_o, bus_if.cause_o, bus_if.epc_o,
                         bus_if.badvaddr_o, bus_if.rdata_o);
                chk($sformatf("v%0d_status", e.idx), bus_if.status_o, e.status);
                chk($sformatf("v%0d_cause", e.idx),  bus_if.cause_o,  e.cause);
                chk($sformatf("v%0d_epc", e.idx),    bus_if.epc_o,    e.epc);
                chk($sformatf("v%0d_badv", e.idx),   bus_if.badvaddr_o, e.badv);
                chk($sformatf("v%0d_rdata", e.idx),  bus_if.rdata_o,  e.rdata);
                chk($sformatf("v%0d_timer", e.idx),
                    {31'd0, bus_if.timer_int_o}, {31'd0, e.timer});
            end
        end
        idle();
        chk("sb_drained", sb_q.size(), 32'd0);

        // -------- Count load and wrap --------
        mtc0(5'd9, 32'hFFFF_FFFE);
        step(1);
        idle();
        chk("cnt_load", bus_if.count_o, 32'hFFFF_FFFE);
        step(2);
        chk("cnt_ffff", bus_if.count_o, 32'hFFFF_FFFF);
        step(2);
        $display("count wrap: count=%08h", bus_if.count_o);
        chk("cnt_wrap", bus_if.count_o, 32'd0);

        // -------- Count write masks a match --------
        mtc0(5'd11, 32'd5);
        step(1);
        mtc0(5'd9, 32'd4);
        step(2);
        idle();
        chk("cntwr_nomatch_timer", {31'd0, bus_if.timer_int_o}, 32'd0);
        chk("cntwr_nomatch_count", bus_if.count_o, 32'd4);
        step(2);
        chk("cnt5_timer", {31'd0, bus_if.timer_int_o}, 32'd1);
        chk("cnt5_count", bus_if.count_o, 32'd5);

        // -------- Compare write beats a coincident match --------
        prev = bus_if.count_o;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(1);
            if (bus_if.count_o != prev) begin
                seen = 1'b1;
                break;
            end
        end
        chk("phase_found", {31'd0, seen}, 32'd1);
        // Count just stepped, so the next edge has no increment.
        mtc0(5'd11, 32'd10);
        step(1);
        mtc0(5'd9, 32'd9);
        step(1);
        idle();
        step(1);
        mtc0(5'd11, 32'd10);
        step(1);
        idle();
        $display("compare write vs match: count=%0d timer_int=%0b",
                 bus_if.count_o, bus_if.timer_int_o);
        chk("cmpwr_wins_count", bus_if.count_o, 32'd10);
        chk("cmpwr_wins_timer", {31'd0, bus_if.timer_int_o}, 32'd0);
        step(1);
        chk("cmpwr_wins_timer2", {31'd0, bus_if.timer_int_o}, 32'd0);

        // -------- reset mid-operation --------
        mtc0(5'd11, 32'd50);
        step(1);
        mtc0(5'd9, 32'd48);
        step(1);
        idle();
        for (int k = 0; k < 8; k++) begin
            if (bus_if.timer_int_o) break;
            step(1);
        end
        chk("pre_rst_timer", {31'd0, bus_if.timer_int_o}, 32'd1);
        chk("pre_rst_count", bus_if.count_o, 32'd50);
        #2;
        rst = 1'b1;
        #1;
        $display("mid-op reset: count=%0d timer_int=%0b", bus_if.count_o, bus_if.timer_int_o);
        chk_reset_state("midrst");
        step(1);
        rst = 1'b0;
        step(1);
        chk("post_rst_edge1_count", bus_if.count_o, 32'd0);
        step(1);
        chk("post_rst_edge2_count", bus_if.count_o, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
